// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 hex keypad scanner: matrix geometry,
// controller state encoding and small helpers for column drive and row
// priority encoding.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int COL_W    = $clog2(NUM_COLS);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DEBOUNCE,
    REPORT,
    RELEASE
  } state_t;

  // One-hot column drive for the column currently being scanned.
  function automatic logic [NUM_COLS-1:0] onehot_col(input logic [COL_W-1:0] idx);
    onehot_col      = '0;
    onehot_col[idx] = 1'b1;
  endfunction

  // Index of the lowest set row; walking downward lets the lowest index
  // overwrite any higher one. Returns 0 for an all-zero pattern.
  function automatic logic [ROW_W-1:0] lowest_row(input logic [NUM_ROWS-1:0] pattern);
    lowest_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (pattern[i]) begin
        lowest_row = ROW_W'(i);
      end
    end
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
// Two-flop synchronizer for a bus of independent, slowly changing lines
// (the keypad row returns). Each bit is synchronized on its own; no
// cross-bit coherence is implied.
// Ports:
//   clk  - destination clock, rising edge
//   rst  - asynchronous, active-high reset (clears both stages)
//   d    - asynchronous input lines
//   q    - synchronized output, two clk edges behind d
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scan controller for a 4x4 hex keypad matrix. Drives the columns,
// samples the synchronized rows, debounces press and release, and hands
// each press to the consumer as a 4-bit code (4*row + col) over a
// valid/ready handshake.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   Row       - raw row returns from the matrix (asynchronous)
//   Col       - column drive: 1111 while idle, one-hot otherwise
//   key_code  - encoded key of the pending/last event
//   key_valid - key_code holds an event not yet accepted
//   key_ready - consumer accepts the event when key_valid is high
//   key_held  - a debounced key is currently down
// Build option:
//   KEYPAD_REPEAT_EN - when defined, a held key re-reports every
//                      REPEAT_CYCLES cycles; otherwise one event per press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] Row,
  output logic [NUM_COLS-1:0] Col,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_held
);

  // The settle time must cover the two synchronizer stages plus the
  // matrix propagation; the repeat interval must leave room for one
  // RELEASE and one REPORT cycle.
  if (SETTLE_CYCLES < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 3) begin : g_param_check
    $error("keypad_scan_ctrl: illegal parameter value");
  end

  // One counter is shared by settle, press debounce and release debounce;
  // those phases never overlap.
  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_ROWS-1:0] rs;

  state_t              state_reg,   state_next;
  logic [COL_W-1:0]    col_idx_reg, col_idx_next;
  logic [CNT_W-1:0]    cnt_reg,     cnt_next;
  logic [NUM_ROWS-1:0] pat_reg,     pat_next;
  logic [ROW_W-1:0]    row_reg,     row_next;
  logic [CODE_W-1:0]   code_reg,    code_next;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  // REPORT is re-entered after REPEAT_CYCLES-1 RELEASE cycles, so with a
  // ready consumer successive events are exactly REPEAT_CYCLES apart.
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 2);
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
`endif

  keypad_sync #(
    .WIDTH(NUM_ROWS)
  ) u_row_sync (
    .clk(clock),
    .rst(reset),
    .d  (Row),
    .q  (rs)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      col_idx_reg <= '0;
      cnt_reg     <= '0;
      pat_reg     <= '0;
      row_reg     <= '0;
      code_reg    <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      col_idx_reg <= col_idx_next;
      cnt_reg     <= cnt_next;
      pat_reg     <= pat_next;
      row_reg     <= row_next;
      code_reg    <= code_next;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg <= rep_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    col_idx_next = col_idx_reg;
    cnt_next     = cnt_reg;
    pat_next     = pat_reg;
    row_next     = row_reg;
    code_next    = code_reg;
`ifdef KEYPAD_REPEAT_EN
    // Cleared unless RELEASE keeps seeing the latched pattern.
    rep_cnt_next = '0;
`endif

    case (state_reg)
      IDLE: begin
        // All columns are driven, so any key down shows up here.
        if (rs != '0) begin
          state_next   = SCAN;
          col_idx_next = '0;
          cnt_next     = '0;
        end
      end

      SCAN: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next = '0;
          if (rs != '0) begin
            pat_next   = rs;
            row_next   = lowest_row(rs);
            state_next = DEBOUNCE;
          end else if (col_idx_reg != COL_W'(NUM_COLS - 1)) begin
            col_idx_next = col_idx_reg + 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (rs != pat_reg) begin
          state_next = IDLE;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = REPORT;
          cnt_next   = '0;
          // key_code only changes when a press is actually reported.
          code_next  = {row_reg, col_idx_reg};
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      REPORT: begin
        // Held regardless of rs: a press is never dropped, even if the
        // key is already up by the time the consumer is ready.
        if (key_ready) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end

      RELEASE: begin
        if (rs != '0) begin
          cnt_next = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`ifdef KEYPAD_REPEAT_EN
        if (rs == pat_reg) begin
          if (rep_cnt_reg == REP_LAST) begin
            state_next = REPORT;
          end else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end
        end
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Once a column is found it stays driven until the key is fully
  // released, which hides keys in other columns.
  assign Col       = (state_reg == IDLE) ? {NUM_COLS{1'b1}} : onehot_col(col_idx_reg);
  assign key_code  = code_reg;
  assign key_valid = (state_reg == REPORT);
  assign key_held  = (state_reg == REPORT) || (state_reg == RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Directed bench for keypad_scan_ctrl. A matrix model turns a 16-bit
// key vector into Row from the DUT's Col. Expected event codes come from
// a priority rule (first column, then lowest row) and are queued; a
// negedge compare process checks every transfer against the queue plus
// per-cycle invariants of the handshake and column drive.
module tb_keypad_scan_ctrl;

  localparam int SETTLE  = 4;
  localparam int DEB     = 4;
  localparam int REP     = 32;
  localparam int LAT_MAX = 2 + 1 + 4 * SETTLE + DEB + 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  Row;
  logic [3:0]  Col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic [15:0] keys;

  int total = 0;
  int bad = 0;
  int events = 0;
  int reps = 0;
  int cyc = 0;
  int exp_q[$];

  logic       prev_stall = 1'b0;
  logic [3:0] prev_code = '0;
  logic [3:0] last_code = '0;
  int         last_xfer_cyc = 0;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .Row      (Row),
    .Col      (Col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held)
  );

  always #5 clock = ~clock;

  // Row[r] = OR over c of (key[4r+c] & Col[c])
  always_comb begin
    Row = '0;
    for (int r = 0; r < 4; r++) begin
      Row[r] = |(keys[4*r +: 4] & Col);
    end
  end

  // Expected code for a set of pressed keys: lowest column wins, then
  // lowest row within it. Later assignments override earlier ones.
  function automatic int winner(input logic [15:0] k);
    winner = -1;
    for (int c = 3; c >= 0; c--) begin
      for (int r = 3; r >= 0; r--) begin
        if (k[4*r + c]) winner = 4 * r + c;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!key_valid && n < bound) begin
      step();
      n++;
    end
    check("valid_seen", int'(key_valid), 1);
  endtask

  task automatic wait_events(input int target, input int bound);
    int n = 0;
    while (events < target && n < bound) begin
      step();
      n++;
    end
    check("event_count", events, target);
  endtask

  task automatic wait_held_low(input int bound);
    int n = 0;
    while (key_held && n < bound) begin
      step();
      n++;
    end
    check("held_released", int'(key_held), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},   int'(Col), 15);
    check({tag, "_code"},  int'(key_code), 0);
    check({tag, "_valid"}, int'(key_valid), 0);
    check({tag, "_held"},  int'(key_held), 0);
  endtask

  // Compare process: invariants every cycle, scoreboard on each transfer.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      check("col_legal", int'(Col == 4'hF || $onehot(Col)), 1);
      if (key_valid) check("held_with_valid", int'(key_held), 1);
      if (prev_stall && key_valid) check("code_stable", int'(key_code), int'(prev_code));
      if (key_valid && key_ready) begin
        if (exp_q.size() > 0) begin
          check("event_code", int'(key_code), exp_q.pop_front());
          events <= events + 1;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (key_code == last_code) begin
          check("repeat_gap", cyc - last_xfer_cyc, REP);
          reps <= reps + 1;
        end
`endif
        else begin
          check("spurious_event", exp_q.size(), 1);
        end
        last_code     <= key_code;
        last_xfer_cyc <= cyc;
      end
      prev_stall <= key_valid && !key_ready;
      prev_code  <= key_code;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int n;
    int base;

    keys      = '0;
    key_ready = 1'b1;
    reset     = 1'b1;

    // Pin the priority model with hand-derived codes.
    check("model_single",       winner(16'h0200), 9);
    check("model_same_col",     winner(16'h4040), 6);
    check("model_col_priority", winner(16'h0028), 5);

    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    repeat (2) step();

    // 1: key 9, latency bound, one event, release timing.
    keys = 16'h0200;
    exp_q.push_back(winner(keys));
    wait_valid(LAT_MAX + 2, n);
    $display("t1 key9 valid after %0d cycles code=%0h", n, key_code);
    check("t1_latency", int'(n <= LAT_MAX), 1);
    check("t1_code", int'(key_code), 9);
    repeat (100) step();
    keys = '0;
    repeat (1 + DEB) step();
    check("t1_held_before_debounce", int'(key_held), 1);
    step();
    check("t1_held_cleared", int'(key_held), 0);
    check("t1_one_event", events, 1);

    // 2: sweep all keys.
    for (int k = 0; k < 16; k++) begin
      base = events;
      keys = 16'(1) << k;
      exp_q.push_back(winner(keys));
      wait_events(base + 1, 40);
      $display("t2 key %0d -> code %0h", k, last_code);
      keys = '0;
      wait_held_low(20);
      repeat (3) step();
    end
    check("t2_queue_drained", exp_q.size(), 0);
    check("t2_events", events, 17);

    // 3: two-cycle glitch on key 5.
    base = events;
    keys = 16'h0020;
    repeat (2) step();
    keys = '0;
    repeat (40) step();
    $display("t3 glitch done events=%0d", events);
    check("t3_no_event", events, base);
    check("t3_col_idle", int'(Col), 15);
    check("t3_held", int'(key_held), 0);

    // 4: stalled consumer, key released during the stall.
    key_ready = 1'b0;
    base = events;
    keys = 16'h0008;
    exp_q.push_back(winner(keys));
    wait_valid(LAT_MAX + 2, n);
    for (int i = 0; i < 50; i++) begin
      step();
      if (i == 10) keys = '0;
      check("t4_valid_held", int'(key_valid), 1);
      check("t4_code", int'(key_code), 3);
    end
    key_ready = 1'b1;
    wait_events(base + 1, 3);
    $display("t4 stalled key3 transferred code=%0h", last_code);
    check("t4_valid_cleared", int'(key_valid), 0);
    wait_held_low(20);

    // 5: keys 6 and 14 together (same column).
    base = events;
    keys = 16'h4040;
    exp_q.push_back(winner(keys));
    wait_events(base + 1, 40);
    $display("t5 two keys -> code %0h", last_code);
    repeat (10) step();
    keys = 16'h4000;
    repeat (30) step();
    check("t5_held_partial", int'(key_held), 1);
    check("t5_single_event", events, base + 1);
    keys = '0;
    wait_held_low(20);
    repeat (30) step();
    check("t5_no_second_event", events, base + 1);

    // 6a: reset during DEBOUNCE on key 0.
    base = events;
    keys = 16'h0001;
    repeat (9) step();
    check("t6a_col_scanning", int'(Col), 1);
    reset = 1'b1;
    #1;
    $display("t6a reset in debounce col=%0h held=%0b", Col, key_held);
    check_reset_outputs("t6a");
    keys = '0;
    repeat (2) step();
    reset = 1'b0;

    // 6b: reset during REPORT with a stalled consumer.
    key_ready = 1'b0;
    keys = 16'h0080;
    wait_valid(LAT_MAX + 2, n);
    check("t6b_code_before_reset", int'(key_code), 7);
    reset = 1'b1;
    #1;
    $display("t6b reset in report code=%0h valid=%0b", key_code, key_valid);
    check_reset_outputs("t6b");
    keys = '0;
    step();
    reset = 1'b0;
    key_ready = 1'b1;
    repeat (40) step();
    check("t6b_event_discarded", events, base);

`ifdef KEYPAD_REPEAT_EN
    // 7: held key A auto-repeats.
    base = reps;
    keys = 16'h0400;
    exp_q.push_back(winner(keys));
    repeat (200) step();
    keys = '0;
    wait_held_low(40);
    $display("t7 repeats=%0d", reps - base);
    check("t7_repeat_count", int'(reps - base >= 4), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
